// File: rtl/sim_monitor.sv
// rtl/sim_monitor.sv - simulation exit/console monitor snooping a write bus
//
// Purpose:
//   Holds the SoC in reset for RST_HOLD cycles, then counts run cycles
//   and watches the bus for an exit-mailbox write (tohost) or a timeout.
//   Once either happens the result flags freeze until rst_n is asserted.
//   Optional console: define SIM_CONSOLE_EN to strobe bytes written to
//   CONSOLE_ADDR out on cons_vld/cons_char.
//
// Ports:
//   clk, rst_n           clock (rising edge), synchronous active-low reset
//   bus_vld/rdy/wr       snooped handshake; a write transfer is all three high
//   bus_addr, bus_wdata  snooped address and write data
//   soc_rst_n            stretched active-low reset to the SoC
//   cons_vld, cons_char  one-cycle console byte strobe and byte
//   done, pass, timeout  sticky completion flags
//   exit_code            bus_wdata[DATA_W-1:1] of the exit write
//   cycle_cnt            number of RUN cycles seen

module sim_monitor #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 32'h8000_1000,
  parameter logic [ADDR_W-1:0] CONSOLE_ADDR   = 32'h8000_2000,
  parameter longint unsigned   TIMEOUT_CYCLES = 1_000_000,
  parameter int                RST_HOLD       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bus_vld,
  input  logic              bus_rdy,
  input  logic              bus_wr,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic              soc_rst_n,
  output logic              cons_vld,
  output logic [7:0]        cons_char,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [DATA_W-2:0] exit_code,
  output logic [63:0]       cycle_cnt
);

  localparam int                HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [63:0]       TO_LAST   = 64'(TIMEOUT_CYCLES - 64'd1);
  localparam bit                TO_EN     = (TIMEOUT_CYCLES != 64'd0);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [HOLD_W-1:0] hold_cnt;

  logic xfer;
  logic exit_hit;
  logic to_hit;

  assign xfer     = bus_vld & bus_rdy & bus_wr;
  assign exit_hit = xfer && (bus_addr == TOHOST_ADDR) && bus_wdata[0];
  // Only meaningful in RUN; the FSM and datapath qualify it with state.
  assign to_hit   = TO_EN && (cycle_cnt == TO_LAST);

  // Decoded from the state register, so it changes only on clock edges.
  assign soc_rst_n = (state != S_HOLD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_HOLD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HOLD: if (hold_cnt == HOLD_LAST) state_nxt = S_RUN;
      S_RUN:  if (exit_hit || to_hit) state_nxt = S_DONE;
      S_DONE: state_nxt = S_DONE;
      default: state_nxt = S_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      exit_code <= '0;
      cycle_cnt <= '0;
    end else begin
      case (state)
        S_HOLD: hold_cnt <= hold_cnt + HOLD_W'(1);
        S_RUN: begin
          // The cycle that ends RUN still counts as a RUN cycle.
          cycle_cnt <= cycle_cnt + 64'd1;
          // Exit write takes priority over a coincident timeout.
          if (exit_hit) begin
            done      <= 1'b1;
            pass      <= (bus_wdata == DATA_W'(1));
            timeout   <= 1'b0;
            exit_code <= bus_wdata[DATA_W-1:1];
          end else if (to_hit) begin
            done      <= 1'b1;
            pass      <= 1'b0;
            timeout   <= 1'b1;
            exit_code <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SIM_CONSOLE_EN
  logic cons_hit;
  assign cons_hit = (state == S_RUN) && xfer && (bus_addr == CONSOLE_ADDR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cons_vld  <= 1'b0;
      cons_char <= 8'h00;
    end else begin
      cons_vld <= cons_hit;
      if (cons_hit) cons_char <= bus_wdata[7:0];
    end
  end
`else
  logic unused_console;
  assign unused_console = ^CONSOLE_ADDR;
  assign cons_vld  = 1'b0;
  assign cons_char = 8'h00;
`endif

endmodule

// File: tb/tb_sim_monitor.sv
// tb/tb_sim_monitor.sv - scoreboard bench for sim_monitor

module tb_sim_monitor;

  localparam logic [31:0] TOHOST  = 32'h8000_1000;
  localparam logic [31:0] CONSOLE = 32'h8000_2000;
  localparam int          HOLD    = 16;
  localparam int          TMO     = 100;

  logic        clk;
  logic        rst_n;
  logic        bus_vld, bus_rdy, bus_wr;
  logic [31:0] bus_addr, bus_wdata;
  logic        soc_rst_n, cons_vld, done, pass, timeout;
  logic [7:0]  cons_char;
  logic [30:0] exit_code;
  logic [63:0] cycle_cnt;

  int vectors = 0;
  int fails   = 0;

  sim_monitor #(
    .ADDR_W(32), .DATA_W(32), .TOHOST_ADDR(TOHOST), .CONSOLE_ADDR(CONSOLE),
    .TIMEOUT_CYCLES(TMO), .RST_HOLD(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus_vld(bus_vld), .bus_rdy(bus_rdy),
    .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .soc_rst_n(soc_rst_n), .cons_vld(cons_vld), .cons_char(cons_char),
    .done(done), .pass(pass), .timeout(timeout), .exit_code(exit_code),
    .cycle_cnt(cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        soc;
    logic        cv;
    logic [7:0]  cc;
    logic        dn;
    logic        ps;
    logic        to;
    logic [30:0] code;
    logic [63:0] cnt;
  } snap_t;

  snap_t exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Reference model: cycles since reset, run cycles, and sticky result.
  int          since_rst;
  longint      runs;
  logic        m_done, m_pass, m_to, m_cv;
  logic [30:0] m_code;
  logic [7:0]  m_cc;

  always @(posedge clk) begin
    snap_t s;
    logic  x;
    if (!rst_n) begin
      since_rst = 0; runs = 0; m_done = 0; m_pass = 0; m_to = 0;
      m_code = 0; m_cv = 0; m_cc = 0;
    end else begin
      x = bus_vld && bus_rdy && bus_wr;
      m_cv = 0;
      if (since_rst >= HOLD && !m_done) begin
        if (x && bus_addr == TOHOST && bus_wdata[0]) begin
          m_done = 1; m_pass = (bus_wdata == 32'd1); m_to = 0;
          m_code = bus_wdata[31:1];
        end else if (runs == TMO - 1) begin
          m_done = 1; m_to = 1; m_pass = 0; m_code = 0;
        end
`ifdef SIM_CONSOLE_EN
        if (x && bus_addr == CONSOLE) begin
          m_cv = 1; m_cc = bus_wdata[7:0];
        end
`endif
        runs++;
      end
      if (since_rst < HOLD) since_rst++;
    end
    s.soc = (since_rst >= HOLD); s.cv = m_cv; s.cc = m_cc; s.dn = m_done;
    s.ps = m_pass; s.to = m_to; s.code = m_code; s.cnt = 64'(runs);
    exp_q.push_back(s);
  end

  // Monitor: compare DUT outputs against the oldest expected snapshot.
  always @(negedge clk) begin
    snap_t s;
    if (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      check("soc_rst_n", 64'(soc_rst_n), 64'(s.soc));
      check("cons_vld",  64'(cons_vld),  64'(s.cv));
      check("cons_char", 64'(cons_char), 64'(s.cc));
      check("done",      64'(done),      64'(s.dn));
      check("pass",      64'(pass),      64'(s.ps));
      check("timeout",   64'(timeout),   64'(s.to));
      check("exit_code", 64'(exit_code), 64'(s.code));
      check("cycle_cnt", cycle_cnt,      s.cnt);
    end
  end

  task automatic drive(input logic v, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    bus_vld = v; bus_rdy = r; bus_wr = w; bus_addr = a; bus_wdata = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
  endtask

  task automatic rand_cycle(input bit allow_exit, input bit allow_rst);
    logic [31:0] a, d;
    int sel;
    sel = int'($urandom % 8);
    d   = $urandom;
    if (sel < 2)      a = TOHOST;
    else if (sel < 4) a = CONSOLE;
    else              a = $urandom;
    if (a == TOHOST && (!allow_exit || ($urandom % 6) != 0)) d[0] = 1'b0;
    if (a == TOHOST && allow_exit && ($urandom % 3) == 0) d = 32'd1;
    rst_n = allow_rst ? (($urandom % 64) != 0) : 1'b1;
    drive(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 3) != 0, a, d);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus_vld = 0; bus_rdy = 0; bus_wr = 0; bus_addr = 0; bus_wdata = 0;
    @(negedge clk);
    check("reset_soc", 64'(soc_rst_n), 64'd0);
    check("reset_cnt", cycle_cnt, 64'd0);
    do_reset();

    // Exit writes during HOLD are ignored; then run to timeout.
    repeat (HOLD) drive(1'b1, 1'b1, 1'b1, TOHOST, 32'd1);
    check("hold_done", 64'(done), 64'd0);
    check("run_soc", 64'(soc_rst_n), 64'd1);
    repeat (TMO + 10) rand_cycle(1'b0, 1'b0);
    repeat (3) drive(1'b1, 1'b1, 1'b1, TOHOST, 32'd1);
    check("tmo_timeout", 64'(timeout), 64'd1);
    check("tmo_cnt", cycle_cnt, 64'(TMO));

    // Console bytes, pass exit, then a later exit write has no effect.
    do_reset();
    idle(HOLD + 5);
    drive(1'b1, 1'b1, 1'b1, CONSOLE, 32'h4F);
`ifdef SIM_CONSOLE_EN
    check("cons_O", 64'(cons_char), 64'h4F);
`else
    check("cons_off", 64'(cons_vld), 64'd0);
`endif
    drive(1'b1, 1'b1, 1'b1, CONSOLE, 32'h4B);
    idle(2);
    drive(1'b1, 1'b1, 1'b1, TOHOST, 32'd1);
    check("pass_flag", 64'(pass), 64'd1);
    idle(3);
    drive(1'b1, 1'b1, 1'b1, TOHOST, 32'd7);
    idle(2);

    // Failing exit code, later pass write ignored.
    do_reset();
    idle(HOLD + 4);
    drive(1'b1, 1'b1, 1'b1, TOHOST, 32'd7);
    check("code3", 64'(exit_code), 64'd3);
    drive(1'b1, 1'b1, 1'b1, TOHOST, 32'd1);
    check("code3_pass", 64'(pass), 64'd0);
    idle(2);

    // Exit write in the same cycle the timeout would fire.
    do_reset();
    idle(HOLD + TMO - 1);
    drive(1'b1, 1'b1, 1'b1, TOHOST, 32'd1);
    check("race_timeout", 64'(timeout), 64'd0);
    check("race_pass", 64'(pass), 64'd1);
    idle(3);

    // Random traffic with random exits and occasional mid-run resets.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      repeat (150) rand_cycle(1'b1, 1'b1);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/sim_monitor.md
SIM_MONITOR -- requirements
Module: sim_monitor

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning bus address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning bus write-data width (min 9).
REQ-003 SHALL have parameter TOHOST_ADDR, default 32'h8000_1000, meaning exit-mailbox address.
REQ-004 SHALL have parameter CONSOLE_ADDR, default 32'h8000_2000, meaning console putchar address.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, meaning RUN-cycle limit (0 = disabled).
REQ-006 SHALL have parameter RST_HOLD, default 16, meaning cycles soc_rst_n is held low (min 1).
REQ-007 SHALL have port clk  input  1  sole clock, rising edge.
REQ-008 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-009 SHALL have ports bus_vld/bus_rdy/bus_wr  input  1 each  snooped request valid, ready, write flag.
REQ-010 SHALL have port bus_addr  input  ADDR_W  snooped address.
REQ-011 SHALL have port bus_wdata  input  DATA_W  snooped write data.
REQ-012 SHALL have port soc_rst_n  output  1  stretched active-low reset to the SoC.
REQ-013 SHALL have ports cons_vld  output  1, cons_char  output  8  console byte strobe and byte.
REQ-014 SHALL have ports done, pass, timeout  output  1 each  sticky completion flags.
REQ-015 SHALL have port exit_code  output  DATA_W-1  program exit code.
REQ-016 SHALL have port cycle_cnt  output  64  RUN-state cycle count.

Function
REQ-017 SHALL define a write transfer as bus_vld & bus_rdy & bus_wr high at a rising edge; full-width exact address compare.
REQ-018 SHALL implement states HOLD, RUN, DONE; HOLD entered from reset.
REQ-019 HOLD: soc_rst_n=0, hold counter increments; after exactly RST_HOLD HOLD cycles -> RUN, soc_rst_n=1 from first RUN cycle.
REQ-020 RUN: cycle_cnt increments by 1 each RUN cycle, wraps modulo 2^64.
REQ-021 RUN: transfer to TOHOST_ADDR with bus_wdata[0]=1 -> DONE; done=1, pass=(bus_wdata==1), exit_code=bus_wdata[DATA_W-1:1], all registered, visible the cycle after the transfer.
REQ-022 RUN: transfer to TOHOST_ADDR with bus_wdata[0]=0 SHALL be ignored.
REQ-023 RUN: when TIMEOUT_CYCLES!=0 and cycle_cnt==TIMEOUT_CYCLES-1 without exit -> DONE with timeout=1, pass=0, exit_code=0.
REQ-024 Exit write and timeout in same cycle: exit write wins, timeout=0.
REQ-025 DONE: flags, exit_code, cycle_cnt frozen; all further transfers ignored; soc_rst_n stays 1; exits only via rst_n.
REQ-026 Transfers in HOLD SHALL be ignored.

Reset
REQ-027 rst_n low at any edge, any state, SHALL force next cycle: state HOLD, hold counter 0, soc_rst_n=0, cons_vld=0, cons_char=0, done=0, pass=0, timeout=0, exit_code=0, cycle_cnt=0.
REQ-028 Reset mid-RUN or in DONE SHALL discard all results and restart the full RST_HOLD sequence.

Configuration
REQ-029 With SIM_CONSOLE_EN defined: RUN-state transfer to CONSOLE_ADDR SHALL pulse cons_vld for one cycle, one cycle after the transfer, with cons_char=bus_wdata[7:0]; back-to-back transfers give back-to-back pulses.
REQ-030 Without SIM_CONSOLE_EN: no console logic; cons_vld and cons_char tied 0; CONSOLE_ADDR writes ignored.

Verification
REQ-031 RST_HOLD=16, release rst_n -> soc_rst_n low exactly 16 cycles, high from cycle 17; cycle_cnt=0 at first RUN cycle.
REQ-032 RUN, write 32'h1 to TOHOST_ADDR -> next cycle done=1, pass=1, exit_code=0, timeout=0; cycle_cnt frozen thereafter.
REQ-033 RUN, write 32'h7 to TOHOST_ADDR -> done=1, pass=0, exit_code=3; later write 32'h1 -> no change.
REQ-034 TIMEOUT_CYCLES=100, no exit write -> done=1, timeout=1 after 100th RUN cycle; variant with exit write in that cycle -> pass=1, timeout=0.
REQ-035 SIM_CONSOLE_EN defined, writes 'O','K' on consecutive cycles -> cons_vld high two consecutive cycles, cons_char 8'h4F then 8'h4B; undefined -> cons_vld stays 0.
REQ-036 rst_n pulsed low one cycle in DONE -> all outputs return to reset values, HOLD sequence repeats; writes during HOLD (vld/rdy without ready excluded) have no effect.
